// File: rtl/fifo_pdata_pkg.sv
// Shared constants and helpers for the 8-bit-write / 32-bit-read pixel FIFO controller.
package fifo_pdata_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_WADDR_W    = 8;
  localparam int DEF_RADDR_W    = 6;

  // Width needed to hold a fill level of 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_pdata_ptr.sv
// Wrap-bit pointer register with synchronous clear and increment.
module fifo_pdata_ptr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_pdata_ctrl.sv
// Byte-write / word-read controller for the embedded-RAM pixel FIFO: pointers, level, flags, pop sequencing.
module fifo_pdata_ctrl
  import fifo_pdata_pkg::*;
#(
  parameter int WADDR_W  = DEF_WADDR_W,
  parameter int RADDR_W  = DEF_RADDR_W,
  parameter int AFULL_TH = 192
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               pop,
  output logic               rd_valid,
  output logic [WADDR_W-1:0] aw,
  output logic               cew,
  output logic [7:0]         dw,
  output logic [RADDR_W-1:0] ar,
  output logic               cer,
  output logic [WADDR_W:0]   level,
  output logic               word_avail,
  output logic               empty,
  output logic               full,
  output logic               afull,
  output logic               err_pop
);

  localparam int LVL_W = level_w(1 << WADDR_W);
  localparam int SHIFT = WADDR_W - RADDR_W;

  logic [WADDR_W:0] w_wptr;
  logic [RADDR_W:0] w_rptr;
  logic [LVL_W-1:0] w_level;
  logic             w_push_acc;
  logic             w_pop_acc;
  logic             w_pop_bad;
  logic             r_rd_valid;
  logic             r_err_pop;

  // Read pointer counts words; scaling it to bytes lets one subtraction yield the byte level.
  assign w_level = w_wptr - {w_rptr, {SHIFT{1'b0}}};

  assign word_avail = (w_level >= LVL_W'(BYTES_PER_WORD));
  assign empty      = (w_level == '0);
  assign full       = (w_level == LVL_W'(1 << WADDR_W));
  assign afull      = (w_level >= LVL_W'(AFULL_TH));
  assign level      = w_level;

  // Flush wins over same-cycle traffic, so both RAM enables are masked by it.
  assign in_ready   = !full;
  assign w_push_acc = in_valid && in_ready && !flush;
  assign w_pop_acc  = pop && word_avail && !flush;
  assign w_pop_bad  = pop && !word_avail && !flush;

  assign cew = w_push_acc;
  assign aw  = w_wptr[WADDR_W-1:0];
  assign dw  = in_data;
  assign cer = w_pop_acc;
  assign ar  = w_rptr[RADDR_W-1:0];

  fifo_pdata_ptr #(.W(WADDR_W + 1)) u_wptr (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (flush),
    .i_inc (w_push_acc),
    .o_ptr (w_wptr)
  );

  fifo_pdata_ptr #(.W(RADDR_W + 1)) u_rptr (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (flush),
    .i_inc (w_pop_acc),
    .o_ptr (w_rptr)
  );

  // RAM output register is off, so read data is valid exactly one cycle after cer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_valid <= 1'b0;
      r_err_pop  <= 1'b0;
    end else if (flush) begin
      r_rd_valid <= 1'b0;
      r_err_pop  <= 1'b0;
    end else begin
      r_rd_valid <= w_pop_acc;
      if (w_pop_bad) begin
        r_err_pop <= 1'b1;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign err_pop  = r_err_pop;

endmodule

// File: doc/fifo_pdata_ctrl.md
Name: fifo_pdata_ctrl

Overview:
- Single-clock controller for the 8-bit-write / 32-bit-read embedded-RAM pixel FIFO (256 x 8 write view, 64 x 32 read view).
- Accepts a byte stream with valid/ready and drives the RAM write port (aw, cew).
- Tracks occupancy and sequences word pops on the read port (ar, cer), then flags returned data valid.
- Sits between the MIPI byte unpacker and the 32-bit pixel packer.

Parameters:
- WADDR_W, 8, write-side (byte) address width; depth = 2^WADDR_W bytes.
- RADDR_W, 6, read-side (word) address width; WADDR_W - RADDR_W must equal 2 (4 bytes per word).
- AFULL_TH, 192, byte level at or above which afull asserts.

Ports:
- clk  in  1  single clock for controller and both RAM ports.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of pointers, level and flags.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  write byte.
- in_ready  out  1  controller can accept a byte.
- pop  in  1  request one 32-bit word.
- rd_valid  out  1  RAM qr holds the popped word this cycle.
- aw  out  WADDR_W  RAM write byte address.
- cew  out  1  RAM write enable.
- dw  out  8  RAM write data.
- ar  out  RADDR_W  RAM read word address.
- cer  out  1  RAM read enable.
- level  out  WADDR_W+1  bytes stored (0..256).
- word_avail  out  1  level >= 4.
- empty  out  1  level == 0.
- full  out  1  level == 256.
- afull  out  1  level >= AFULL_TH.
- err_pop  out  1  sticky: pop while word_avail=0.

Behaviour:
- Reset: while rstn=0, all pointers, level, rd_valid and err_pop are 0; empty=1, all other flags 0.
- Pointers:
  - wptr has WADDR_W+1 bits (byte units, wrap bit); rptr has RADDR_W+1 bits (word units).
  - level = wptr - {rptr,2'b00}, computed modulo 2^(WADDR_W+1); all flags derive combinationally from the registered level.
- Push: push_acc = in_valid & in_ready, with in_ready = !full.
  - cew = push_acc, aw = wptr[WADDR_W-1:0], dw = in_data, all combinational.
  - wptr increments on the clock edge.
- Pop: pop_acc = pop & word_avail.
  - cer = pop_acc, ar = rptr[RADDR_W-1:0], combinational; rptr increments on the edge.
  - rd_valid is registered pop_acc: it is high exactly 1 cycle after cer, because the RAM output register is off.
  - Pops may be back-to-back every cycle.
- Byte order: the word at address n holds bytes 4n..4n+3, with byte 4n in qr[7:0] and byte 4n+3 in qr[31:24].
- Simultaneous push and pop in one cycle: both accepted; level changes by +1-4 = -3.
- Full/empty decisions use the registered level only.
  - At full, in_ready=0 even if a pop is accepted in the same cycle.
  - No read-during-write collision is possible, because a word is poppable only after all 4 of its bytes were written in earlier cycles.
- Wrap-around: pointers roll over naturally. The wrap bit distinguishes full (256) from empty (0).
- Pop with word_avail=0 (including partial words, level 1..3): ignored, so no cer and no rptr change; err_pop is set and held.
- Flush: wptr, rptr, rd_valid and err_pop go to 0 on the next edge. Flush has priority over a push or pop in the same cycle; cew and cer are forced 0 that cycle.
- Reset or flush mid-operation: partial bytes are discarded and no rd_valid is issued for a pop in flight. A rd_valid already registered before the flush edge still completes.

Decomposition:
- Shared package fifo_pdata_pkg holds:
  - constants BYTES_PER_WORD=4 and the default WADDR_W/RADDR_W values;
  - a level-width function clog2(depth)+1.
- Optional sub-module fifo_pdata_ptr: a generic wrap-bit pointer register with increment and clear, instantiated for the write and read pointers.
- The RAM wrapper is instantiated at the level above, not inside this block.

Test Plan:
- Push 4 bytes 0x11,0x22,0x33,0x44, then pop -> ar=0 and cer=1 in the pop cycle; rd_valid=1 one cycle later with qr=0x44332211; level back to 0 and empty=1.
- Push 3 bytes, then pop -> no cer, err_pop=1 and stays 1, level stays 3; flush -> err_pop=0, level=0.
- Push 256 bytes -> full=1, in_ready=0, afull asserted from level 192. Pop plus push in the same cycle at full -> pop accepted, push stalled, level=252 next cycle.
- Stream 1024 bytes with continuous pops whenever word_avail=1 -> 256 words read in order, pointers wrap 4 times, no err_pop; every qr equals the expected little-endian packing.
- Steady-state simultaneous push and pop -> level decrements by 3 per cycle; rd_valid follows every cer by exactly 1 cycle.
- Deassert rstn asynchronously mid-stream with level=100 -> outputs clear immediately without waiting for clk; after release, the first 4 pushed bytes read back at ar=0.
